// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and stall scheduler: tracks in-flight destinations in EX/MEM/WB shadows.
// Optional HAZARD_STALL_CNT_EN adds a saturating 32-bit StallCount output.
module fwd_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] ID_Rs,
    input  logic [RW-1:0] ID_Rt,
    input  logic          ID_UseRs,
    input  logic          ID_UseRt,
    input  logic          ID_RegWrite,
    input  logic [RW-1:0] ID_WriteReg,
    input  logic          ID_MemToReg,
    input  logic          ID_MultiCycle,
    input  logic          Flush,
    output logic          Stall,
    output logic          EX_Flush,
    output logic          EX_Hold,
    output logic [1:0]    AluSrcA_Sel,
    output logic [1:0]    AluSrcB_Sel
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]   StallCount
`endif
);

    localparam int CW = $clog2(MC_LAT) + 1;
    localparam bit MC_EN = (MC_LAT > 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          load;
        logic          mc;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    shadow_t       ex_q, ex_d;
    shadow_t       mem_q, mem_d;
    shadow_t       wb_q, wb_d;
    logic [1:0]    sel_a_q, sel_a_d;
    logic [1:0]    sel_b_q, sel_b_d;
    shadow_t       id_entry_s;
    logic          load_use_s;

    // Nearest valid producer wins; the WB entry is covered by the write-first regfile.
    function automatic logic [1:0] fwd_sel(
        input logic          use_src,
        input logic [RW-1:0] src,
        input shadow_t       ex,
        input shadow_t       mem
    );
        logic [1:0] sel;
        if (!use_src) begin
            sel = SEL_RF;
        end else if (ex.valid && (ex.rd == src)) begin
            sel = SEL_MEM;
        end else if (mem.valid && (mem.rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Shadow entry for the instruction in ID; $0 writes never become valid producers.
    always_comb begin
        id_entry_s.valid = ID_RegWrite && (ID_WriteReg != {RW{1'b0}});
        id_entry_s.rd    = ID_WriteReg;
        id_entry_s.load  = ID_MemToReg;
        id_entry_s.mc    = ID_MultiCycle;
    end

    // Next-state, shadow advance and select computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        load_use_s = 1'b0;
        case (state_q)
            RUN: begin
                load_use_s = ex_q.valid && ex_q.load &&
                             ((ID_UseRs && (ID_Rs == ex_q.rd)) ||
                              (ID_UseRt && (ID_Rt == ex_q.rd)));
                wb_d  = mem_q;
                mem_d = ex_q;
                if (Flush || load_use_s) begin
                    ex_d    = BUBBLE;
                    sel_a_d = SEL_RF;
                    sel_b_d = SEL_RF;
                    state_d = RUN;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    ex_d    = id_entry_s;
                    sel_a_d = fwd_sel(ID_UseRs, ID_Rs, ex_q, mem_q);
                    sel_b_d = fwd_sel(ID_UseRt, ID_Rt, ex_q, mem_q);
                    if (MC_EN && ID_MultiCycle) begin
                        state_d = MC_BUSY;
                        cnt_d   = CW'(MC_LAT - 1);
                    end else begin
                        state_d = RUN;
                        cnt_d   = {CW{1'b0}};
                    end
                end
            end
            MC_BUSY: begin
                // EX and selects hold; the pipeline behind EX drains bubbles.
                mem_d = BUBBLE;
                wb_d  = mem_q;
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = RUN;
                end else begin
                    state_d = MC_BUSY;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
                ex_d    = BUBBLE;
                mem_d   = BUBBLE;
                wb_d    = BUBBLE;
                sel_a_d = SEL_RF;
                sel_b_d = SEL_RF;
            end
        endcase
    end

    // Combinational pipeline control outputs.
    always_comb begin
        Stall    = (state_q == MC_BUSY) || load_use_s;
        EX_Flush = (state_q == RUN) && load_use_s;
        EX_Hold  = (state_q == MC_BUSY);
    end

    // State, counter, shadows and registered selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= {CW{1'b0}};
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign AluSrcA_Sel = sel_a_q;
    assign AluSrcB_Sel = sel_b_q;

    // WB and the load/mc flags of later stages are tracked but only EX/MEM rd feed forwarding.
    logic unused_shadow_bits;
    assign unused_shadow_bits = ^{wb_q, mem_q.load, mem_q.mc, ex_q.mc};

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl (MC_LAT=4, RW=5).
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, ID_WriteReg;
    logic       ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemToReg, ID_MultiCycle;
    logic       Flush;
    logic       Stall, EX_Flush, EX_Hold;
    logic [1:0] AluSrcA_Sel, AluSrcB_Sel;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] StallCount;
`endif

    int checks   = 0;
    int failures = 0;

    fwd_hazard_ctrl #(.MC_LAT(4), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_RegWrite(ID_RegWrite), .ID_WriteReg(ID_WriteReg),
        .ID_MemToReg(ID_MemToReg), .ID_MultiCycle(ID_MultiCycle),
        .Flush(Flush),
        .Stall(Stall), .EX_Flush(EX_Flush), .EX_Hold(EX_Hold),
        .AluSrcA_Sel(AluSrcA_Sel), .AluSrcB_Sel(AluSrcB_Sel)
`ifdef HAZARD_STALL_CNT_EN
        , .StallCount(StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic rw, input logic [4:0] wr,
                          input logic ld, input logic mc);
        ID_Rs = rs; ID_Rt = rt; ID_UseRs = urs; ID_UseRt = urt;
        ID_RegWrite = rw; ID_WriteReg = wr; ID_MemToReg = ld; ID_MultiCycle = mc;
        #1;
    endtask

    task automatic drain();
        Flush = 1'b0;
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Flush = 1'b0;
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", Stall); end
        checks++; if (EX_Flush !== 1'b0) begin failures++; $display("FAIL reset_exflush got=%0b exp=0", EX_Flush); end
        checks++; if (EX_Hold !== 1'b0) begin failures++; $display("FAIL reset_exhold got=%0b exp=0", EX_Hold); end
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL reset_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
`ifdef HAZARD_STALL_CNT_EN
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL reset_stallcount got=%0d exp=0", StallCount); end
`endif
    endtask

    // add $3,$1,$2 ; add $4,$3,$5
    task automatic test_ex_forward();
        drain();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        id_set(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL exfwd_stall got=%0b exp=0", Stall); end
        tick();
        checks++; if (AluSrcA_Sel !== 2'b10) begin failures++; $display("FAIL exfwd_selA got=%b exp=10", AluSrcA_Sel); end
        checks++; if (AluSrcB_Sel !== 2'b00) begin failures++; $display("FAIL exfwd_selB got=%b exp=00", AluSrcB_Sel); end
    endtask

    // add $3 ; nop ; sub $6,$7,$3
    task automatic test_mem_forward();
        drain();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        id_set(5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL memfwd_stall got=%0b exp=0", Stall); end
        tick();
        checks++; if (AluSrcA_Sel !== 2'b00) begin failures++; $display("FAIL memfwd_selA got=%b exp=00", AluSrcA_Sel); end
        checks++; if (AluSrcB_Sel !== 2'b01) begin failures++; $display("FAIL memfwd_selB got=%b exp=01", AluSrcB_Sel); end
    endtask

    // lw $2,($1) ; add $4,$2,$2
    task automatic test_load_use();
        drain();
        id_set(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        id_set(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", Stall); end
        checks++; if (EX_Flush !== 1'b1) begin failures++; $display("FAIL lu_exflush got=%0b exp=1", EX_Flush); end
        checks++; if (EX_Hold !== 1'b0) begin failures++; $display("FAIL lu_exhold got=%0b exp=0", EX_Hold); end
        tick();
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_stall_after got=%0b exp=0", Stall); end
        checks++; if (EX_Flush !== 1'b0) begin failures++; $display("FAIL lu_exflush_after got=%0b exp=0", EX_Flush); end
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL lu_bubble_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
        tick();
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0101) begin failures++; $display("FAIL lu_sels got=%b exp=0101", {AluSrcA_Sel, AluSrcB_Sel}); end
    endtask

    // Writes to $0 are never forwarded nor cause load-use stalls.
    task automatic test_zero_reg();
        drain();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        id_set(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%0b exp=0", Stall); end
        tick();
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL zero_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
        drain();
        id_set(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        id_set(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL zero_load_stall got=%0b exp=0", Stall); end
    endtask

    // Two producers of $3: nearest (EX) wins; unused source reads 00.
    task automatic test_priority();
        drain();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        id_set(5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        checks++; if (AluSrcA_Sel !== 2'b10) begin failures++; $display("FAIL prio_selA got=%b exp=10", AluSrcA_Sel); end
        checks++; if (AluSrcB_Sel !== 2'b00) begin failures++; $display("FAIL prio_selB_unused got=%b exp=00", AluSrcB_Sel); end
    endtask

    // Flushed producers vanish; Flush with load-use still stalls.
    task automatic test_flush();
        drain();
        id_set(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        id_set(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL flush_cycle_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
        tick();
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL flush_killed_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
        drain();
        id_set(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        id_set(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        Flush = 1'b1;
        #1;
        checks++; if ({Stall, EX_Flush} !== 2'b11) begin failures++; $display("FAIL flush_lu got=%b exp=11", {Stall, EX_Flush}); end
        tick();
        Flush = 1'b0;
        checks++; if (AluSrcA_Sel !== 2'b00) begin failures++; $display("FAIL flush_lu_selA got=%b exp=00", AluSrcA_Sel); end
    endtask

    // add $5 ; mult $8 <- $5,$6 (4 cycles) ; consumer of $8 and $5
    task automatic test_multicycle();
        drain();
        id_set(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        id_set(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL mc_entry_stall got=%0b exp=0", Stall); end
        tick();
        id_set(5'd8, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({Stall, EX_Hold, EX_Flush} !== 3'b110) begin failures++; $display("FAIL mc_busy_%0d got=%b exp=110", i, {Stall, EX_Hold, EX_Flush}); end
            checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b1000) begin failures++; $display("FAIL mc_hold_sels_%0d got=%b exp=1000", i, {AluSrcA_Sel, AluSrcB_Sel}); end
            tick();
        end
        checks++; if ({Stall, EX_Hold} !== 2'b00) begin failures++; $display("FAIL mc_release got=%b exp=00", {Stall, EX_Hold}); end
        tick();
        checks++; if (AluSrcA_Sel !== 2'b10) begin failures++; $display("FAIL mc_cons_selA got=%b exp=10", AluSrcA_Sel); end
        checks++; if (AluSrcB_Sel !== 2'b00) begin failures++; $display("FAIL mc_cons_selB got=%b exp=00", AluSrcB_Sel); end
    endtask

    // Reset during the second MC_BUSY cycle.
    task automatic test_reset_mid_mc();
        drain();
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
        tick();
        id_set(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++; if (EX_Hold !== 1'b1) begin failures++; $display("FAIL rmc_busy got=%0b exp=1", EX_Hold); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({Stall, EX_Hold, EX_Flush} !== 3'b000) begin failures++; $display("FAIL rmc_ctrl got=%b exp=000", {Stall, EX_Hold, EX_Flush}); end
        checks++; if ({AluSrcA_Sel, AluSrcB_Sel} !== 4'b0000) begin failures++; $display("FAIL rmc_sels got=%b exp=0000", {AluSrcA_Sel, AluSrcB_Sel}); end
`ifdef HAZARD_STALL_CNT_EN
        checks++; if (StallCount !== 32'd0) begin failures++; $display("FAIL rmc_stallcount got=%0d exp=0", StallCount); end
`endif
        id_set(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        checks++; if (AluSrcA_Sel !== 2'b00) begin failures++; $display("FAIL rmc_cleared_selA got=%b exp=00", AluSrcA_Sel); end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_zero_reg();
        test_priority();
        test_flush();
        test_multicycle();
        test_reset_mid_mc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and stall scheduler for the EX-stage operand muxes of the 5-stage MIPS pipeline. It tracks destination registers of in-flight instructions in internal shadow stages (EX/MEM/WB). It produces registered 2-bit forward selects for ALU source A and B, load-use stalls, and multi-cycle EX hold. It sits beside the ID/EX pipeline register and drives the SrcA/SrcB mux selects, PC/IF-ID freeze and ID/EX bubble.

Parameters:
MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op (mult/div); legal range 1..16
RW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ID_Rs  in  RW  source reg A of instruction in ID
ID_Rt  in  RW  source reg B of instruction in ID
ID_UseRs  in  1  instruction reads Rs
ID_UseRt  in  1  instruction reads Rt
ID_RegWrite  in  1  instruction writes a register
ID_WriteReg  in  RW  destination register
ID_MemToReg  in  1  instruction is a load
ID_MultiCycle  in  1  instruction is a multi-cycle EX op
Flush  in  1  control-hazard kill of the ID instruction
Stall  out  1  freeze PC and IF/ID (combinational)
EX_Flush  out  1  load bubble into ID/EX (combinational)
EX_Hold  out  1  hold ID/EX and EX unit (combinational)
AluSrcA_Sel  out  2  registered select: 00 reg file, 01 WriteBackData, 10 MEM_AluResult
AluSrcB_Sel  out  2  same encoding for operand B

Behaviour:
- Shadow entry per stage: valid, rd, load, mc. An entry is valid only if RegWrite=1 and rd!=0; $0 is never forwarded.
- States: RUN, MC_BUSY. Counter cnt of width clog2(MC_LAT)+1.
- Reset (synchronous): state=RUN, cnt=0, all shadow valids=0, AluSrcA_Sel=AluSrcB_Sel=00. Stall, EX_Flush and EX_Hold therefore read 0.
- Load-use condition (RUN only): ex.valid & ex.load & ((ID_UseRs & ID_Rs==ex.rd) | (ID_UseRt & ID_Rt==ex.rd)). When true: Stall=1 and EX_Flush=1; EX shadow becomes a bubble.
- RUN advance each cycle: WB<=MEM, MEM<=EX.
  - EX<=ID info, or a bubble if load-use or Flush.
  - Flush has priority over load-use for the EX entry. Stall still follows the load-use condition.
- Select computation in RUN, per source, registered on the advance edge:
  - 10 if ex.valid & ex.rd==src;
  - else 01 if mem.valid & mem.rd==src;
  - else 00.
  - Nearest producer wins. A source with Use=0 gives 00.
  - On a load-use or Flush cycle, selects load 00.
- Regfile is write-first; the current WB entry is never a forward source.
- Multi-cycle entry: when an instruction with ID_MultiCycle=1 advances into EX and MC_LAT>1, then next state is MC_BUSY and cnt=MC_LAT-1.
- MC_BUSY:
  - Stall=1, EX_Hold=1, EX_Flush=0.
  - EX shadow and selects hold.
  - MEM<=bubble, WB<=MEM.
  - cnt decrements. At cnt==1 the next state is RUN.
  - Flush and ID inputs are ignored.
  - Total EX occupancy is exactly MC_LAT cycles.
- MC_LAT=1: MC_BUSY is never entered.
- Back-to-back: a load followed by a dependent instruction gives 1 stall. The dependent instruction then gets sel 01 (load now in WB position).
- Reset mid-MC_BUSY: returns to RUN and clears all shadows on the next edge.

Optional Feature:
HAZARD_STALL_CNT_EN
- Defined: adds output StallCount (32b), reset 0, +1 on every cycle with Stall=1, saturates at 0xFFFFFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- add $3 then add $4,$3,$5 back-to-back -> no stall; AluSrcA_Sel=10 in the consumer's EX cycle.
- add $3; nop; sub $6,$7,$3 -> AluSrcB_Sel=01, Stall=0.
- lw $2; add $4,$2,$2 -> one cycle Stall=1 and EX_Flush=1; then both selects=01.
- ALU writes $0 followed by a reader of $0 -> selects 00.
- With MC_LAT=4, mult then add -> Stall=EX_Hold=1 for exactly 3 cycles, MEM receives 3 bubbles, then normal flow.
- Assert rst during cycle 2 of MC_BUSY -> next cycle state RUN, Stall=0, selects 00; with HAZARD_STALL_CNT_EN, StallCount=0.
